// File: rtl/move_controller.sv
// Cursor/turn sequencer for the TicTacToe board: arbitrates button presses,
// steps a 3x3 cursor with hold-to-repeat, and writes moves to the board store.
module move_controller #(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int CNT_W        = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_down,
  input  logic [4:0] btn_state,
  input  logic [8:0] board_occ,
  input  logic       game_over,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [3:0] wr_cell,
  output logic       wr_player,
  output logic [3:0] cursor,
  output logic       turn,
  output logic       invalid_pulse,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  state_t           state_q, state_d;
  logic [3:0]       cursor_q, cursor_d;
  logic             turn_q, turn_d;
  logic             wr_req_q, wr_req_d;
  logic [3:0]       wr_cell_q, wr_cell_d;
  logic             wr_player_q, wr_player_d;
  logic             invalid_pulse_q, invalid_pulse_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_active_q, rpt_active_d;
  logic             rpt_first_q, rpt_first_d;
  logic [1:0]       rpt_dir_q, rpt_dir_d;

  logic [15:0]      occ_ext;
  logic [1:0]       press_dir;
  logic [CNT_W-1:0] rpt_last;

  // Cursor is kept as a linear index; row/col wrap is done on decoded fields.
  function automatic logic [3:0] step_cursor(input logic [3:0] cur, input logic [1:0] dir);
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] base;
    if (cur >= 4'd6) begin
      row = 2'd2;
      base = 4'd6;
    end else if (cur >= 4'd3) begin
      row = 2'd1;
      base = 4'd3;
    end else begin
      row = 2'd0;
      base = 4'd0;
    end
    col = 2'(cur - base);
    case (dir)
      DIR_UP:    row = (row == 2'd0) ? 2'd2 : row - 2'd1;
      DIR_DOWN:  row = (row == 2'd2) ? 2'd0 : row + 2'd1;
      DIR_LEFT:  col = (col == 2'd0) ? 2'd2 : col - 2'd1;
      default:   col = (col == 2'd2) ? 2'd0 : col + 2'd1;
    endcase
    case (row)
      2'd0:    base = 4'd0;
      2'd1:    base = 4'd3;
      default: base = 4'd6;
    endcase
    return base + {2'b00, col};
  endfunction

  assign occ_ext  = {7'b0, board_occ};
  assign rpt_last = rpt_first_q ? DELAY_LAST : RATE_LAST;

  always_comb begin
    if (btn_down[0])      press_dir = DIR_UP;
    else if (btn_down[1]) press_dir = DIR_DOWN;
    else if (btn_down[2]) press_dir = DIR_LEFT;
    else                  press_dir = DIR_RIGHT;
  end

  always_comb begin
    state_d         = state_q;
    cursor_d        = cursor_q;
    turn_d          = turn_q;
    wr_req_d        = wr_req_q;
    wr_cell_d       = wr_cell_q;
    wr_player_d     = wr_player_q;
    invalid_pulse_d = 1'b0;
    rpt_cnt_d       = rpt_cnt_q;
    rpt_active_d    = rpt_active_q;
    rpt_first_d     = rpt_first_q;
    rpt_dir_d       = rpt_dir_q;

    case (state_q)
      IDLE: begin
        if (game_over) begin
          state_d      = LOCKED;
          rpt_active_d = 1'b0;
          rpt_cnt_d    = '0;
        end else if (btn_down[4]) begin
          state_d      = CHECK;
          rpt_active_d = 1'b0;
          rpt_cnt_d    = '0;
        end else if (btn_down[3:0] != 4'b0) begin
          cursor_d     = step_cursor(cursor_q, press_dir);
          rpt_dir_d    = press_dir;
          rpt_cnt_d    = '0;
          rpt_active_d = 1'b1;
          rpt_first_d  = 1'b1;
        end else if (rpt_active_q) begin
          // A fresh press above always beats a repeat step in the same cycle.
          if (!btn_state[rpt_dir_q]) begin
            rpt_active_d = 1'b0;
            rpt_cnt_d    = '0;
          end else if (rpt_cnt_q == rpt_last) begin
            cursor_d    = step_cursor(cursor_q, rpt_dir_q);
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (occ_ext[cursor_q]) begin
          invalid_pulse_d = 1'b1;
          state_d         = IDLE;
        end else begin
          wr_req_d    = 1'b1;
          wr_cell_d   = cursor_q;
          wr_player_d = turn_q;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          turn_d   = ~turn_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = LOCKED;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cursor_q        <= 4'd4;
      turn_q          <= 1'b0;
      wr_req_q        <= 1'b0;
      wr_cell_q       <= 4'd0;
      wr_player_q     <= 1'b0;
      invalid_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
      rpt_cnt_q       <= '0;
      rpt_active_q    <= 1'b0;
      rpt_first_q     <= 1'b0;
      rpt_dir_q       <= 2'd0;
    end else begin
      state_q         <= state_d;
      cursor_q        <= cursor_d;
      turn_q          <= turn_d;
      wr_req_q        <= wr_req_d;
      wr_cell_q       <= wr_cell_d;
      wr_player_q     <= wr_player_d;
      invalid_pulse_q <= invalid_pulse_d;
      busy_q          <= busy_d;
      rpt_cnt_q       <= rpt_cnt_d;
      rpt_active_q    <= rpt_active_d;
      rpt_first_q     <= rpt_first_d;
      rpt_dir_q       <= rpt_dir_d;
    end
  end

  assign wr_req        = wr_req_q;
  assign wr_cell       = wr_cell_q;
  assign wr_player     = wr_player_q;
  assign cursor        = cursor_q;
  assign turn          = turn_q;
  assign invalid_pulse = invalid_pulse_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed self-checking bench for move_controller, using short repeat
// timing so hold-to-repeat steps can be observed within a few dozen cycles.
module tb_move_controller;

  logic       clk;
  logic       rst;
  logic [4:0] btn_down;
  logic [4:0] btn_state;
  logic [8:0] board_occ;
  logic       game_over;
  logic       wr_ack;
  logic       wr_req;
  logic [3:0] wr_cell;
  logic       wr_player;
  logic [3:0] cursor;
  logic       turn;
  logic       invalid_pulse;
  logic       busy;

  int checkCount;
  int passCount;

  localparam logic [4:0] BTN_UP     = 5'b00001;
  localparam logic [4:0] BTN_DOWN   = 5'b00010;
  localparam logic [4:0] BTN_LEFT   = 5'b00100;
  localparam logic [4:0] BTN_RIGHT  = 5'b01000;
  localparam logic [4:0] BTN_SELECT = 5'b10000;

  move_controller #(
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_down     (btn_down),
    .btn_state    (btn_state),
    .board_occ    (board_occ),
    .game_over    (game_over),
    .wr_ack       (wr_ack),
    .wr_req       (wr_req),
    .wr_cell      (wr_cell),
    .wr_player    (wr_player),
    .cursor       (cursor),
    .turn         (turn),
    .invalid_pulse(invalid_pulse),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pulse btn_down for exactly one cycle.
  task automatic applyStimulus(input logic [4:0] pulse);
    btn_down = pulse;
    tick();
    btn_down = 5'b0;
  endtask

  logic [3:0] expCursor;

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    btn_down   = 5'b0;
    btn_state  = 5'b0;
    board_occ  = 9'h000;
    game_over  = 1'b0;
    wr_ack     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_cursor", 32'(cursor), 32'd4);
    checkOutput("rst_turn", 32'(turn), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
    checkOutput("rst_wr_cell", 32'(wr_cell), 32'd0);
    checkOutput("rst_wr_player", 32'(wr_player), 32'd0);
    checkOutput("rst_invalid", 32'(invalid_pulse), 32'd0);

    // Basic moves and wrapping
    btn_down = BTN_RIGHT;
    checkOutput("right_before_edge", 32'(cursor), 32'd4);
    tick();
    btn_down = 5'b0;
    checkOutput("right_step", 32'(cursor), 32'd5);
    applyStimulus(BTN_RIGHT);
    checkOutput("right_wrap", 32'(cursor), 32'd3);
    applyStimulus(BTN_UP);
    checkOutput("up_to_0", 32'(cursor), 32'd0);
    applyStimulus(BTN_RIGHT);
    checkOutput("right_to_1", 32'(cursor), 32'd1);
    applyStimulus(BTN_UP);
    checkOutput("up_wrap", 32'(cursor), 32'd7);
    applyStimulus(BTN_DOWN);
    checkOutput("down_wrap", 32'(cursor), 32'd1);
    applyStimulus(BTN_LEFT);
    checkOutput("left_wrap", 32'(cursor), 32'd0);
    applyStimulus(BTN_LEFT | BTN_RIGHT);
    checkOutput("left_beats_right", 32'(cursor), 32'd2);
    applyStimulus(BTN_DOWN | BTN_LEFT);
    checkOutput("down_beats_left", 32'(cursor), 32'd5);
    applyStimulus(BTN_LEFT);
    checkOutput("back_to_4", 32'(cursor), 32'd4);

    // Select wins arbitration; free cell leads to a held write request
    btn_down = BTN_UP | BTN_LEFT | BTN_SELECT;
    tick();
    btn_down = 5'b0;
    checkOutput("sel_busy_check", 32'(busy), 32'd1);
    checkOutput("sel_cursor_n1", 32'(cursor), 32'd4);
    checkOutput("sel_no_req_n1", 32'(wr_req), 32'd0);
    tick();
    checkOutput("sel_wr_req", 32'(wr_req), 32'd1);
    checkOutput("sel_wr_cell", 32'(wr_cell), 32'd4);
    checkOutput("sel_wr_player", 32'(wr_player), 32'd0);
    checkOutput("sel_cursor_n2", 32'(cursor), 32'd4);
    for (int i = 0; i < 5; i++) begin
      btn_down = BTN_RIGHT;
      tick();
      checkOutput("hold_wr_req", 32'(wr_req), 32'd1);
      checkOutput("hold_wr_cell", 32'(wr_cell), 32'd4);
      checkOutput("hold_wr_player", 32'(wr_player), 32'd0);
      checkOutput("hold_cursor", 32'(cursor), 32'd4);
    end
    btn_down = 5'b0;
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    checkOutput("ack_wr_req", 32'(wr_req), 32'd0);
    checkOutput("ack_turn", 32'(turn), 32'd1);
    checkOutput("ack_busy", 32'(busy), 32'd0);

    // Stray ack in IDLE does nothing
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    checkOutput("stray_ack_turn", 32'(turn), 32'd1);
    checkOutput("stray_ack_busy", 32'(busy), 32'd0);

    // Select on an occupied cell
    board_occ = 9'h010;
    applyStimulus(BTN_SELECT);
    checkOutput("occ_busy_check", 32'(busy), 32'd1);
    checkOutput("occ_invalid_n1", 32'(invalid_pulse), 32'd0);
    tick();
    checkOutput("occ_invalid_n2", 32'(invalid_pulse), 32'd1);
    checkOutput("occ_no_req_n2", 32'(wr_req), 32'd0);
    tick();
    checkOutput("occ_invalid_n3", 32'(invalid_pulse), 32'd0);
    checkOutput("occ_no_req_n3", 32'(wr_req), 32'd0);
    checkOutput("occ_turn", 32'(turn), 32'd1);
    checkOutput("occ_busy_idle", 32'(busy), 32'd0);
    board_occ = 9'h000;

    // Hold-to-repeat: delay 8, rate 4, down from cell 1
    applyStimulus(BTN_UP);
    checkOutput("rpt_start_1", 32'(cursor), 32'd1);
    btn_state = BTN_DOWN;
    applyStimulus(BTN_DOWN);
    checkOutput("rpt_n1", 32'(cursor), 32'd4);
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (k < 9)       expCursor = 4'd4;
      else if (k < 13) expCursor = 4'd7;
      else if (k < 17) expCursor = 4'd1;
      else             expCursor = 4'd4;
      checkOutput($sformatf("rpt_n%0d", k), 32'(cursor), 32'(expCursor));
    end
    btn_state = 5'b0;
    for (int k = 0; k < 10; k++) tick();
    checkOutput("rpt_released", 32'(cursor), 32'd4);

    // Ack accepted in the first WRITE cycle
    applyStimulus(BTN_SELECT);
    tick();
    checkOutput("fast_wr_req", 32'(wr_req), 32'd1);
    checkOutput("fast_wr_player", 32'(wr_player), 32'd1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    checkOutput("fast_ack_req", 32'(wr_req), 32'd0);
    checkOutput("fast_ack_turn", 32'(turn), 32'd0);

    // game_over during WRITE, then LOCKED until reset
    applyStimulus(BTN_RIGHT);
    checkOutput("go_cursor_5", 32'(cursor), 32'd5);
    applyStimulus(BTN_SELECT);
    tick();
    checkOutput("go_wr_req", 32'(wr_req), 32'd1);
    checkOutput("go_wr_cell", 32'(wr_cell), 32'd5);
    game_over = 1'b1;
    tick();
    checkOutput("go_write_held", 32'(wr_req), 32'd1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    checkOutput("go_ack_req", 32'(wr_req), 32'd0);
    checkOutput("go_ack_turn", 32'(turn), 32'd1);
    checkOutput("go_ack_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("locked_busy", 32'(busy), 32'd1);
    applyStimulus(BTN_RIGHT);
    checkOutput("locked_cursor", 32'(cursor), 32'd5);
    game_over = 1'b0;
    applyStimulus(BTN_SELECT);
    tick();
    checkOutput("locked_no_req", 32'(wr_req), 32'd0);
    checkOutput("locked_busy_hold", 32'(busy), 32'd1);
    checkOutput("locked_turn", 32'(turn), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2_cursor", 32'(cursor), 32'd4);
    checkOutput("rst2_turn", 32'(turn), 32'd0);
    checkOutput("rst2_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
